ps2_scan_receiver: RTL and testbench
====================================

// Module: ps2_scan_receiver
// PURPOSE
//  Parametrised PS/2 keyboard receiver, fully synchronous to the system Clock.
//  Synchronises and deglitches PS2 clock/data, frames 11-bit packets, checks start/parity/stop, times out stalled frames.
//  Folds E0/F0 prefixes into flags; queues decoded key events in a show-ahead FIFO with valid/ready handshake.
//  Feeds the cursor/colour control logic in front of VGA_controller.
// PARAMETERS
//  SYNC_STAGES     2      synchroniser flops on iPS2_CLK/iPS2_DATA (>=2)
//  FILTER_LEN      4      consecutive equal samples needed to accept a new PS2 clock level
//  TIMEOUT_CYCLES  25000  max Clock cycles between PS2 falling edges inside a frame
//  FIFO_DEPTH      4      event queue depth (power of 2, >=2)
// PORTS
//  Clock          in   1  system clock; all logic posedge
//  Reset          in   1  synchronous, active-high
//  iPS2_CLK       in   1  raw PS/2 clock (asynchronous)
//  iPS2_DATA      in   1  raw PS/2 data (asynchronous)
//  iReady         in   1  consumer accepts head entry when oValid=1
//  oValid         out  1  FIFO not empty
//  oScanCode      out  8  head entry scan code
//  oBreak         out  1  head entry was preceded by F0 (key release)
//  oExtended      out  1  head entry was preceded by E0
//  oParityError   out  1  one-cycle pulse: frame failed odd parity
//  oFrameError    out  1  one-cycle pulse: stop bit 0 or timeout
//  oOverflow      out  1  sticky: event dropped on full FIFO; cleared only by Reset
//  oBusy          out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (synchronous, active-high): next edge → all outputs 0, FSM IDLE, FIFO empty, prefix flags cleared; sync/filter flops = 1.
//    Partial frame discarded; mid-frame Reset has the same effect.
//  - Sync/filter: filtered clock changes level only after FILTER_LEN equal synchronised samples.
//    Filtered 1->0 gives a one-cycle strobe; synchronised data is sampled in the strobe cycle.
//  - Timeout counter: cleared on every strobe and in IDLE.
//  - FSM states and transitions:
//      IDLE:  strobe with data=0 -> SHIFT, bitcnt=0; strobe with data=1 ignored.
//      SHIFT: each strobe shifts data in LSB first (8 data, parity, stop); after 10th bit -> CHECK.
//             Counter reaching TIMEOUT_CYCLES-1 -> oFrameError pulse, prefix flags cleared, IDLE.
//      CHECK: one cycle, then IDLE.
//             Parity ok when ^{data,parity}=1; stop ok when 1. Parity failure takes priority.
//             Parity bad -> oParityError pulse. Stop bad (parity ok) -> oFrameError pulse.
//             Either error -> no push, prefix flags cleared.
//  - Prefix decode on good byte:
//      E0 -> set ext flag, no push.
//      F0 -> set brk flag, no push.
//      other -> push {ext,brk,byte}, clear both flags.
//  - Latency: stop-bit strobe at cycle N, CHECK at N+1; pushed entry visible (oValid=1) at N+2.
//  - FIFO entries are 10 bits wide; pop when oValid&iReady.
//      oScanCode/oBreak/oExtended show the head entry; forced 0 when oValid=0.
//      Push while full without pop -> entry dropped, contents unchanged, oOverflow<=1.
//      Push and pop in same cycle when full -> both happen, no overflow.
//      Push into empty FIFO with iReady=1 -> entry shown one cycle, then popped.
//      Pointers wrap modulo FIFO_DEPTH.
//  - oBusy = (state != IDLE).
// TESTING  (PS2 bit period 2000 Clock cycles; defaults)
//  1 frame 0x1D, parity 1, stop 1, iReady=1 -> oValid 1 cycle at N+2, oScanCode=1D, oBreak=0, oExtended=0
//  2 frames F0,1D -> exactly one event: 1D, oBreak=1, oExtended=0; E0,F0,75 -> 75, oBreak=1, oExtended=1
//  3 F0, then 0x1D with parity 0, then 0x1C -> oParityError pulse, no event for 1D; event 1C with oBreak=0
//  4 iReady=0, send 15,16,17,18,19 -> oOverflow=1; pops return 15,16,17,18 then oValid=0
//  5 start + 4 bits then idle -> oFrameError pulse at TIMEOUT_CYCLES, oBusy=0; next full 0x1C decodes correctly
//  6 Reset asserted mid-frame with 2 queued events -> next cycle all outputs 0; following 0x1D decodes normally

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: sync/deglitch, 11-bit framing with parity/stop/timeout checks, E0/F0 folding, event FIFO.
// Latency: stop-bit strobe N -> entry visible at N+2; backpressure via iReady, full FIFO drops the event and sets oOverflow.
module ps2_scan_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DATA,
   input  logic       iReady,
   output logic       oValid,
   output logic [7:0] oScanCode,
   output logic       oBreak,
   output logic       oExtended,
   output logic       oParityError,
   output logic       oFrameError,
   output logic       oOverflow,
   output logic       oBusy
);
   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } evt_t;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic                   filt_q, filt_d, filt_prev_q, filt_prev_d;
   logic [FCW-1:0]         fcnt_q, fcnt_d;
   logic [TCW-1:0]         tcnt_q, tcnt_d;
   state_t                 state_q, state_d;
   logic [3:0]             bitcnt_q, bitcnt_d;
   logic [9:0]             shreg_q, shreg_d;
   logic                   ext_q, ext_d, brk_q, brk_d;
   logic                   perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
   evt_t                   mem_q [FIFO_DEPTH];
   evt_t                   mem_d [FIFO_DEPTH];
   logic [PW:0]            wptr_q, wptr_d, rptr_q, rptr_d;

   logic       clk_s, dat_s, stb, push, pop, empty, full;
   logic [PW:0] count;
   evt_t       head;

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];
   assign stb   = filt_prev_q & ~filt_q;

   // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], iPS2_CLK};
      dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], iPS2_DATA};
      filt_d      = filt_q;
      filt_prev_d = filt_q;
      fcnt_d      = '0;
      if (clk_s != filt_q) begin
         if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_s;
         else                                fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      ext_d    = ext_q;
      brk_d    = brk_q;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      push     = 1'b0;
      tcnt_d   = '0;
      case (state_q)
         IDLE: begin
            if (stb && !dat_s) begin
               state_d  = SHIFT;
               bitcnt_d = '0;
            end
         end
         SHIFT: begin
            if (stb) begin
               shreg_d  = {dat_s, shreg_q[9:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 4'd9) state_d = CHECK;
            end else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
               ferr_d  = 1'b1;
               ext_d   = 1'b0;
               brk_d   = 1'b0;
               state_d = IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            // shreg holds {stop, parity, data[7:0]}
            if (^shreg_q[8:0] == 1'b0) begin
               perr_d = 1'b1;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
            end else if (!shreg_q[9]) begin
               ferr_d = 1'b1;
               ext_d  = 1'b0;
               brk_d  = 1'b0;
            end else if (shreg_q[7:0] == 8'hE0) begin
               ext_d = 1'b1;
            end else if (shreg_q[7:0] == 8'hF0) begin
               brk_d = 1'b1;
            end else begin
               push  = 1'b1;
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign count = wptr_q - rptr_q;
   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(FIFO_DEPTH));
   assign pop   = !empty && iReady;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      if (pop) rptr_d = rptr_q + 1'b1;
      if (push) begin
         if (!full || pop) begin
            mem_d[wptr_q[PW-1:0]] = '{ext: ext_q, brk: brk_q, code: shreg_q[7:0]};
            wptr_d = wptr_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         clk_sync_q  <= '1;
         dat_sync_q  <= '1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= '0;
         tcnt_q      <= '0;
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovf_q       <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         dat_sync_q  <= dat_sync_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_prev_d;
         fcnt_q      <= fcnt_d;
         tcnt_q      <= tcnt_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shreg_q     <= shreg_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovf_q       <= ovf_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
      end
   end

   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
   end

   assign head         = mem_q[rptr_q[PW-1:0]];
   assign oValid       = !empty;
   assign oScanCode    = empty ? 8'h00 : head.code;
   assign oBreak       = !empty && head.brk;
   assign oExtended    = !empty && head.ext;
   assign oParityError = perr_q;
   assign oFrameError  = ferr_q;
   assign oOverflow    = ovf_q;
   assign oBusy        = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver; shortened timeout and PS/2 bit period keep the run small.
module tb_ps2_scan_receiver;
   localparam int HALF = 40;
   localparam int TMO  = 400;

   logic       Clock, Reset, iPS2_CLK, iPS2_DATA, iReady;
   logic       oValid, oBreak, oExtended, oParityError, oFrameError, oOverflow, oBusy;
   logic [7:0] oScanCode;

   int checks = 0;
   int errors = 0;

   logic [9:0] evq [$];
   int         perr_n = 0;
   int         ferr_n = 0;

   ps2_scan_receiver #(
      .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)
   ) dut (
      .Clock(Clock), .Reset(Reset), .iPS2_CLK(iPS2_CLK), .iPS2_DATA(iPS2_DATA),
      .iReady(iReady), .oValid(oValid), .oScanCode(oScanCode), .oBreak(oBreak),
      .oExtended(oExtended), .oParityError(oParityError), .oFrameError(oFrameError),
      .oOverflow(oOverflow), .oBusy(oBusy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Records every accepted entry as {ext, brk, code} and counts error pulses.
   always @(negedge Clock) begin
      if (oValid && iReady) evq.push_back({oExtended, oBreak, oScanCode});
      if (oParityError) perr_n++;
      if (oFrameError) ferr_n++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic ps2_bit(input logic b);
      iPS2_DATA = b;
      tick(HALF);
      iPS2_CLK = 1'b0;
      tick(HALF);
      iPS2_CLK = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic par, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(par);
      ps2_bit(stop);
      tick(HALF);
   endtask

   task automatic send(input logic [7:0] d);
      send_byte(d, ~^d, 1'b1);
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      tick(3);
      checks++;
      if ({oValid, oScanCode, oBreak, oExtended} !== 11'h0) begin
         errors++; $display("FAIL reset_head: got %h want 0", {oValid, oScanCode, oBreak, oExtended});
      end
      checks++;
      if ({oParityError, oFrameError, oOverflow, oBusy} !== 4'h0) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {oParityError, oFrameError, oOverflow, oBusy});
      end
      Reset = 1'b0;
      tick(2);
   endtask

   task automatic test_single;
      int lat;
      logic [9:0] got;
      lat = 0;
      got = '1;
      iReady = 1'b1;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(1'(8'h1D >> i));
      ps2_bit(1'b1);
      iPS2_DATA = 1'b1;
      tick(HALF);
      iPS2_CLK = 1'b0;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
         tick(1);
         if (oValid) begin
            lat = k;
            got = {oExtended, oBreak, oScanCode};
         end
      end
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", lat); end
      checks++;
      if (got !== 10'h01D) begin errors++; $display("FAIL single_entry: got %h want 01d", got); end
      tick(1);
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL single_popped: oValid %b want 0", oValid); end
      tick(HALF - 9);
      iPS2_CLK = 1'b1;
      tick(HALF);
   endtask

   task automatic test_prefix;
      int base;
      base = evq.size();
      send(8'hF0);
      send(8'h1D);
      checks++;
      if (evq.size() - base !== 1) begin errors++; $display("FAIL break_count: got %0d want 1", evq.size() - base); end
      checks++;
      if ((evq.size() > base ? evq[base] : 10'h3FF) !== 10'h11D) begin
         errors++; $display("FAIL break_entry: got %h want 11d", evq.size() > base ? evq[base] : 10'h3FF);
      end
      base = evq.size();
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      checks++;
      if (evq.size() - base !== 1) begin errors++; $display("FAIL ext_count: got %0d want 1", evq.size() - base); end
      checks++;
      if ((evq.size() > base ? evq[base] : 10'h000) !== 10'h375) begin
         errors++; $display("FAIL ext_entry: got %h want 375", evq.size() > base ? evq[base] : 10'h000);
      end
   endtask

   task automatic test_parity;
      int base, p0;
      base = evq.size();
      p0 = perr_n;
      send(8'hF0);
      send_byte(8'h1D, 1'b0, 1'b1);
      send(8'h1C);
      checks++;
      if (perr_n - p0 !== 1) begin errors++; $display("FAIL parity_pulse: got %0d want 1", perr_n - p0); end
      checks++;
      if (evq.size() - base !== 1) begin errors++; $display("FAIL parity_count: got %0d want 1", evq.size() - base); end
      checks++;
      if ((evq.size() > base ? evq[base] : 10'h3FF) !== 10'h01C) begin
         errors++; $display("FAIL parity_entry: got %h want 01c", evq.size() > base ? evq[base] : 10'h3FF);
      end
   endtask

   task automatic test_overflow;
      int base;
      logic [7:0] exp_codes [4];
      exp_codes = '{8'h15, 8'h16, 8'h17, 8'h18};
      iReady = 1'b0;
      send(8'h15);
      send(8'h16);
      send(8'h17);
      send(8'h18);
      checks++;
      if (oOverflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", oOverflow); end
      send(8'h19);
      checks++;
      if (oOverflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", oOverflow); end
      checks++;
      if ({oValid, oScanCode} !== 9'h115) begin errors++; $display("FAIL ovf_head: got %h want 115", {oValid, oScanCode}); end
      base = evq.size();
      iReady = 1'b1;
      tick(10);
      iReady = 1'b0;
      checks++;
      if (evq.size() - base !== 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", evq.size() - base); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ((evq.size() > base + i ? evq[base + i] : 10'h3FF) !== {2'b00, exp_codes[i]}) begin
            errors++; $display("FAIL ovf_pop%0d: got %h want %h", i,
                               evq.size() > base + i ? evq[base + i] : 10'h3FF, {2'b00, exp_codes[i]});
         end
      end
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL ovf_drained: oValid %b want 0", oValid); end
   endtask

   task automatic test_timeout;
      int lat, base;
      logic busy_mid;
      lat = 0;
      busy_mid = 1'b0;
      iReady = 1'b1;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      iPS2_DATA = 1'b1;
      tick(HALF);
      iPS2_CLK = 1'b0;
      for (int k = 1; k <= 2 * TMO && lat == 0; k++) begin
         tick(1);
         if (k == HALF) begin
            iPS2_CLK = 1'b1;
            busy_mid = oBusy;
         end
         if (oFrameError) lat = k;
      end
      checks++;
      if (busy_mid !== 1'b1) begin errors++; $display("FAIL tmo_busy_mid: got %b want 1", busy_mid); end
      checks++;
      if (lat !== TMO + 7) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", lat, TMO + 7); end
      checks++;
      if (oBusy !== 1'b0) begin errors++; $display("FAIL tmo_busy_after: got %b want 0", oBusy); end
      tick(1);
      checks++;
      if (oFrameError !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b want 0", oFrameError); end
      base = evq.size();
      send(8'h1C);
      checks++;
      if ((evq.size() == base + 1 ? evq[base] : 10'h3FF) !== 10'h01C) begin
         errors++; $display("FAIL tmo_recover: got %h (n=%0d) want 01c", evq.size() > base ? evq[base] : 10'h3FF,
                            evq.size() - base);
      end
   endtask

   task automatic test_reset_mid;
      int base;
      iReady = 1'b0;
      send(8'h21);
      send(8'h22);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      checks++;
      if ({oValid, oBusy, oOverflow} !== 3'b111) begin
         errors++; $display("FAIL rstmid_pre: got %b want 111", {oValid, oBusy, oOverflow});
      end
      Reset = 1'b1;
      tick(1);
      checks++;
      if ({oValid, oScanCode, oBreak, oExtended, oParityError, oFrameError, oOverflow, oBusy} !== 15'h0) begin
         errors++; $display("FAIL rstmid_outputs: got %h want 0",
                            {oValid, oScanCode, oBreak, oExtended, oParityError, oFrameError, oOverflow, oBusy});
      end
      Reset = 1'b0;
      iReady = 1'b1;
      tick(2);
      base = evq.size();
      send(8'h1D);
      checks++;
      if ((evq.size() == base + 1 ? evq[base] : 10'h3FF) !== 10'h01D) begin
         errors++; $display("FAIL rstmid_after: got %h (n=%0d) want 01d", evq.size() > base ? evq[base] : 10'h3FF,
                            evq.size() - base);
      end
   endtask

   task automatic test_full_push_pop;
      int base;
      iReady = 1'b0;
      base = evq.size();
      for (int i = 0; i < 4; i++) send(8'h31 + 8'(i));
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(1'(8'h35 >> i));
      ps2_bit(~^8'h35);
      iPS2_DATA = 1'b1;
      tick(HALF);
      iPS2_CLK = 1'b0;
      tick(7);
      iReady = 1'b1;
      tick(HALF - 7);
      iPS2_CLK = 1'b1;
      tick(20);
      iReady = 1'b0;
      checks++;
      if (oOverflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %b want 0", oOverflow); end
      checks++;
      if (evq.size() - base !== 5) begin errors++; $display("FAIL fullpp_count: got %0d want 5", evq.size() - base); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ((evq.size() > base + i ? evq[base + i] : 10'h3FF) !== {2'b00, 8'h31 + 8'(i)}) begin
            errors++; $display("FAIL fullpp_pop%0d: got %h want %h", i,
                               evq.size() > base + i ? evq[base + i] : 10'h3FF, {2'b00, 8'h31 + 8'(i)});
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      iPS2_CLK = 1'b1;
      iPS2_DATA = 1'b1;
      iReady = 1'b0;
      test_reset;
      test_single;
      test_prefix;
      test_parity;
      test_overflow;
      test_timeout;
      test_reset_mid;
      test_full_push_pop;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
